// File: rtl/lut_ctrl_pkg.sv
// Shared types and constants for the gate-vs-ROM LUT self-test controller.
package lut_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      WAIT   = 3'd2,
      CHECK  = 3'd3,
      FINISH = 3'd4
   } state_e;

   localparam logic [31:0] OK_ALL   = '1;
   localparam logic        SEL_GATE = 1'b0;
   localparam logic        SEL_ROM  = 1'b1;

   // Vector address covers both operands side by side.
   function automatic int unsigned addr_w(input int unsigned w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/selftest_settle_timer.sv
// Settle-delay counter: loaded when a vector is applied, counts down while waiting.
module selftest_settle_timer
   import lut_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic expire_c
);

   localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(SETTLE);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High on the last waiting cycle, so the wait lasts exactly SETTLE cycles.
   assign expire_c = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/lut_selftest_ctrl.sv
// Self-test sequencer and path selector for the gate-vs-ROM LUT block.
// Optional SELFTEST_STOP_ON_FAIL_EN: abort the sweep at the first mismatching vector.
module lut_selftest_ctrl
   import lut_ctrl_pkg::*;
#(
   parameter int unsigned W      = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [addr_w(W):0]   err_cnt,
   output logic [addr_w(W)-1:0] fail_addr,
   output logic [W-1:0]         dut_in0,
   output logic [W-1:0]         dut_in1,
   input  logic [W-1:0]         dut_ok,
   output logic                 dut_sel
);

   localparam int unsigned ADDR_W = addr_w(W);
   localparam int unsigned ERR_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] fail_q, fail_d;
   logic [W-1:0]      in0_q, in0_d;
   logic [W-1:0]      in1_q, in1_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              sel_q, sel_d;
   logic              tmr_load, tmr_dec, tmr_expire_c;
   logic              mismatch;

   selftest_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .expire_c (tmr_expire_c)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      err_d    = err_q;
      fail_d   = fail_q;
      in0_d    = in0_q;
      in1_d    = in1_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      sel_d    = sel_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      mismatch = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = '0;
               err_d   = '0;
               pass_d  = 1'b0;
               sel_d   = SEL_GATE;
               busy_d  = 1'b1;
               state_d = APPLY;
            end
         end
         APPLY: begin
            in0_d    = addr_q[ADDR_W-1:W];
            in1_d    = addr_q[W-1:0];
            tmr_load = 1'b1;
            state_d  = (SETTLE == 0) ? CHECK : WAIT;
         end
         WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_expire_c) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Only this state looks at the block's compare flag.
            mismatch = (dut_ok != W'(OK_ALL));
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
               if (err_q == '0) begin
                  fail_d = addr_q;
               end
            end
`ifdef SELFTEST_STOP_ON_FAIL_EN
            if (mismatch || (addr_q == ADDR_LAST)) begin
               state_d = FINISH;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = APPLY;
            end
`else
            if (addr_q == ADDR_LAST) begin
               state_d = FINISH;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = APPLY;
            end
`endif
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == '0);
            sel_d   = (err_q == '0) ? SEL_ROM : SEL_GATE;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         in0_q   <= '0;
         in1_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         sel_q   <= SEL_GATE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         sel_q   <= sel_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign fail_addr = fail_q;
   assign dut_in0   = in0_q;
   assign dut_in1   = in1_q;
   assign dut_sel   = sel_q;

endmodule

// File: tb/tb_lut_selftest_ctrl.sv
// Bench for lut_selftest_ctrl: two instances (SETTLE=1 and SETTLE=0) against a timeline model.
module tb_lut_selftest_ctrl;

`ifdef SELFTEST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic       sel;
      logic [4:0] err;
      logic [3:0] fail;
      logic [3:0] ain;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start [2];
   logic       busy [2];
   logic       done [2];
   logic       pass [2];
   logic       sel [2];
   logic [4:0] err [2];
   logic [3:0] fail [2];
   logic [1:0] in0 [2];
   logic [1:0] in1 [2];
   logic [1:0] ok [2];

   int          errors = 0;
   int          checks = 0;
   int          n = 0;
   bit          cmp_en = 1'b0;
   bit          mv [2];
   int          ms [2];
   logic [15:0] mm [2];
   logic [15:0] fmask [2];
   logic [3:0]  bin [2];
   logic [3:0]  bfail [2];

   always #5 clk = ~clk;

   lut_selftest_ctrl #(.W(2), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_cnt(err[0]), .fail_addr(fail[0]), .dut_in0(in0[0]),
      .dut_in1(in1[0]), .dut_ok(ok[0]), .dut_sel(sel[0])
   );

   lut_selftest_ctrl #(.W(2), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_cnt(err[1]), .fail_addr(fail[1]), .dut_in0(in0[1]),
      .dut_in1(in1[1]), .dut_ok(ok[1]), .dut_sel(sel[1])
   );

   function automatic int per(input int i);
      return (i == 0) ? 3 : 2;
   endfunction

   // Expected outputs k edges after the edge that accepted start.
   function automatic exp_t eval(input bit v, input int k, input int p, input logic [15:0] m,
                                 input logic [3:0] b_in, input logic [3:0] b_fail);
      exp_t e;
      int   f, last, len, cnt, j;
      e      = '0;
      e.ain  = b_in;
      e.fail = b_fail;
      if (!v) return e;
      f = -1;
      for (int x = 15; x >= 0; x--) if (m[x]) f = x;
      last = (STOP && f >= 0) ? f : 15;
      len  = (last + 1) * p + 1;
      cnt  = 0;
      for (int x = 0; x <= last; x++) if (m[x] && (x + 1) * p <= k) cnt++;
      e.busy = (k < len);
      e.done = (k == len);
      e.err  = 5'(cnt);
      if (k >= 1) begin
         j = (k - 1) / p;
         e.ain = 4'((j > last) ? last : j);
      end
      if (f >= 0 && (f + 1) * p <= k) e.fail = 4'(f);
      e.pass = (k >= len) && (cnt == 0);
      e.sel  = e.pass;
      return e;
   endfunction

   function automatic exp_t eval_i(input int i, input int abs_edge);
      return eval(mv[i], abs_edge - ms[i], per(i), mm[i], bin[i], bfail[i]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model advance: a sweep starts when start is seen while the instance is idle.
   always @(posedge clk or negedge rst_n) begin : model
      exp_t e;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; ms[i] = 0; mm[i] = '0; bin[i] = '0; bfail[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            e = eval_i(i, n);
            if (!e.busy && start[i]) begin
               bin[i] = e.ain; bfail[i] = e.fail; mm[i] = fmask[i];
               ms[i] = n + 1; mv[i] = 1'b1;
            end
         end
         n = n + 1;
      end
   end

   // Per-cycle compare, then drive the block's compare flag for the next edge.
   always @(negedge clk) begin : compare
      exp_t e;
      int   k, p, len;
      for (int i = 0; i < 2; i++) begin
         e = eval_i(i, n);
         if (cmp_en) begin
            chk($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(e.busy));
            chk($sformatf("i%0d_done", i), 32'(done[i]), 32'(e.done));
            chk($sformatf("i%0d_pass", i), 32'(pass[i]), 32'(e.pass));
            chk($sformatf("i%0d_sel", i), 32'(sel[i]), 32'(e.sel));
            chk($sformatf("i%0d_err", i), 32'(err[i]), 32'(e.err));
            chk($sformatf("i%0d_fail", i), 32'(fail[i]), 32'(e.fail));
            chk($sformatf("i%0d_in", i), 32'({in0[i], in1[i]}), 32'(e.ain));
         end
         p = per(i);
         k = n - ms[i];
         len = 0;
         for (int x = 0; x < 16; x++) if (!(STOP && len != 0) && mm[i][x]) len = x + 1;
         len = ((STOP && len != 0) ? len : 16) * p + 1;
         if (mv[i] && k < len - 1 && (k % p) == p - 1)
            ok[i] = mm[i][k / p] ? 2'($urandom_range(0, 2)) : 2'b11;
         else
            ok[i] = 2'($urandom);
      end
   end

   task automatic run_sweep(input int i, input logic [15:0] m, output int lat);
      int e0;
      bit seen;
      fmask[i] = m;
      @(negedge clk); start[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0; e0 = n;
      seen = 1'b0;
      lat  = -1;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (done[i]) begin seen = 1'b1; lat = n - e0; end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL sweep%0d_timeout: got no done expected done within 200 cycles", i);
      end
   endtask

   function automatic logic [15:0] rand_mask();
      case ($urandom_range(0, 3))
         0:       return 16'h0;
         1:       return 16'h1 << $urandom_range(0, 15);
         default: return 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
   endfunction

   initial begin : main
      int lat, dcnt, dedge, e0;
      bit seen;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; fmask[i] = '0; ok[i] = 2'b11; mv[i] = 1'b0; ms[i] = 0;
         mm[i] = '0; bin[i] = '0; bfail[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_sel", 32'(sel[0]), 0);
      chk("rst_err", 32'(err[1]), 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // Healthy sweep, SETTLE=1
      run_sweep(0, 16'h0, lat);
      chk("t1_lat", lat, 49);
      chk("t1_pass", 32'(pass[0]), 1);
      chk("t1_err", 32'(err[0]), 0);
      chk("t1_sel", 32'(sel[0]), 1);
      // Single fault at vector A
      run_sweep(0, 16'h0400, lat);
      chk("t2_err", 32'(err[0]), 1);
      chk("t2_fail", 32'(fail[0]), 32'hA);
      chk("t2_pass", 32'(pass[0]), 0);
      chk("t2_sel", 32'(sel[0]), 0);
      // Faults at 3 and C
      run_sweep(0, 16'h1008, lat);
      chk("t3_err", 32'(err[0]), STOP ? 1 : 2);
      chk("t3_fail", 32'(fail[0]), 32'h3);
      chk("t3_lat", lat, STOP ? 13 : 49);
      // SETTLE=0 instance
      run_sweep(1, 16'h0, lat);
      chk("t6_lat", lat, 33);
      chk("t6_pass", 32'(pass[1]), 1);
      run_sweep(1, 16'h0001, lat);
      chk("t6_fail", 32'(fail[1]), 0);
      chk("t6_err", 32'(err[1]), 1);

      // Start held high for 60 cycles
      fmask[0] = 16'h0;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); e0 = n;
      dcnt = 0; dedge = -1;
      for (int c = 0; c < 59; c++) begin
         @(negedge clk);
         if (done[0]) begin dcnt++; if (dedge < 0) dedge = n - e0; end
      end
      start[0] = 1'b0;
      chk("t4_dcnt", dcnt, 1);
      chk("t4_edge", dedge, 49);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (done[0]) seen = 1'b1;
      end
      chk("t4_second_done", 32'(seen), 1);

      // Asynchronous reset mid-sweep at vector 7
      run_sweep(0, 16'h0000, lat);
      fmask[0] = 16'h0004;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if ({in0[0], in1[0]} == 4'h7) seen = 1'b1;
      end
      chk("t5_reach7", 32'(seen), 1);
      chk("t5_pre_err", 32'(err[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy[0]), 0);
      chk("t5_sel", 32'(sel[0]), 0);
      chk("t5_err", 32'(err[0]), 0);
      chk("t5_fail", 32'(fail[0]), 0);
      chk("t5_in", 32'({in0[0], in1[0]}), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_idle", 32'(busy[0]), 0);

      // Randomized traffic on both instances
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if (c % 40 == 0) for (int i = 0; i < 2; i++) fmask[i] = rand_mask();
         for (int i = 0; i < 2; i++) start[i] = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end
      end
      for (int i = 0; i < 2; i++) start[i] = 1'b0;
      repeat (60) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
